// File: rtl/iter_mul_unit_pkg.sv
// Shared encodings for the iterative multiplier: operation codes and FSM states.
package iter_mul_unit_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MLA   = 2'b01,
        OP_UMULL = 2'b10,
        OP_SMULL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Long ops write a hi result through the auxiliary port.
    function automatic logic is_long(input op_e op);
        return (op == OP_UMULL) || (op == OP_SMULL);
    endfunction

endpackage

// File: rtl/iter_mul_unit_cond_negate.sv
// Conditional two's-complement negate: y_c = neg ? -x : x.
module iter_mul_unit_cond_negate #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y_c
);

    assign y_c = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle shift-add multiplier (MUL/MLA/UMULL/SMULL) with fixed WIDTH-cycle iteration
// and registered lo/hi/flags/write-address results presented with a one-cycle done pulse.
module iter_mul_unit
    import iter_mul_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       wa_lo_in,
    input  logic [3:0]       wa_hi_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             hi_we,
    output logic [3:0]       wa_lo,
    output logic [3:0]       wa_hi,
    output logic [1:0]       flags
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_q;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic [3:0]       wa_lo_q;
    logic [3:0]       wa_hi_q;

    logic             accept_c;
    logic             smull_in_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH:0]   upper_sum_c;
    logic [PW-1:0]    prod_step_c;
    logic [PW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] lo_res_c;
    logic [WIDTH-1:0] hi_res_c;
    logic             n_c;
    logic             z_c;

    assign accept_c   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign smull_in_c = (op_e'(op) == OP_SMULL);

    // SMULL works on magnitudes; unsigned W-bit magnitude keeps -2^(W-1) exact.
    iter_mul_unit_cond_negate #(.W(WIDTH)) u_abs_a (
        .x   (a),
        .neg (smull_in_c && a[WIDTH-1]),
        .y_c (abs_a_c)
    );

    iter_mul_unit_cond_negate #(.W(WIDTH)) u_abs_b (
        .x   (b),
        .neg (smull_in_c && b[WIDTH-1]),
        .y_c (abs_b_c)
    );

    // One shift-add step: add into the upper half, then shift right with carry-in.
    always_comb begin
        upper_sum_c = {1'b0, prod[PW-1:WIDTH]};
        if (mplier[0]) begin
            upper_sum_c = upper_sum_c + {1'b0, mcand};
        end
        prod_step_c = {upper_sum_c, prod[WIDTH-1:1]};
    end

    iter_mul_unit_cond_negate #(.W(PW)) u_fix (
        .x   (prod),
        .neg (sign_q),
        .y_c (prod_fix_c)
    );

    always_comb begin
        lo_res_c = prod_fix_c[WIDTH-1:0];
        hi_res_c = '0;
        if (op_q == OP_MLA) begin
            lo_res_c = prod_fix_c[WIDTH-1:0] + acc_q;
        end
        if (is_long(op_q)) begin
            hi_res_c = prod_fix_c[PW-1:WIDTH];
            n_c      = prod_fix_c[PW-1];
            z_c      = (prod_fix_c == '0);
        end else begin
            n_c      = lo_res_c[WIDTH-1];
            z_c      = (lo_res_c == '0);
        end
    end

    // FSM, iteration datapath and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_MUL;
            mcand   <= '0;
            mplier  <= '0;
            acc_q   <= '0;
            prod    <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            wa_lo_q <= '0;
            wa_hi_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lo      <= '0;
            hi      <= '0;
            hi_we   <= 1'b0;
            wa_lo   <= '0;
            wa_hi   <= '0;
            flags   <= '0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                state   <= ST_CALC;
                busy    <= 1'b1;
                op_q    <= op_e'(op);
                acc_q   <= acc;
                wa_lo_q <= wa_lo_in;
                wa_hi_q <= wa_hi_in;
                mcand   <= abs_a_c;
                mplier  <= abs_b_c;
                sign_q  <= smull_in_c && (a[WIDTH-1] ^ b[WIDTH-1]);
                prod    <= '0;
                cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_CALC: begin
                        prod   <= prod_step_c;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        lo    <= lo_res_c;
                        hi    <= hi_res_c;
                        hi_we <= is_long(op_q);
                        flags <= {n_c, z_c};
                        wa_lo <= wa_lo_q;
                        wa_hi <= wa_hi_q;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Self-checking bench for iter_mul_unit: arithmetic reference model with a done-cycle
// scoreboard, plus directed vectors with literal expectations.
module tb_iter_mul_unit;

    localparam int unsigned W       = 32;
    localparam int unsigned LATENCY = W + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, acc;
    logic [3:0]  wa_lo_in, wa_hi_in;
    logic        busy, done, hi_we;
    logic [31:0] lo, hi;
    logic [3:0]  wa_lo, wa_hi;
    logic [1:0]  flags;

    iter_mul_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .acc      (acc),
        .wa_lo_in (wa_lo_in),
        .wa_hi_in (wa_hi_in),
        .busy     (busy),
        .done     (done),
        .lo       (lo),
        .hi       (hi),
        .hi_we    (hi_we),
        .wa_lo    (wa_lo),
        .wa_hi    (wa_hi),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        hi_we;
        logic [1:0]  flags;
        logic [3:0]  wl;
        logic [3:0]  wh;
        int          acc_cyc;
    } exp_t;

    exp_t expq[$];
    exp_t ce;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                   input logic [31:0] macc, input logic [3:0] wl, input logic [3:0] wh);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] t;
        longint      sa, sb;
        logic        lng;
        case (mop)
            2'b00:   begin t = ma * mb;        p = {32'h0, t}; end
            2'b01:   begin t = ma * mb + macc; p = {32'h0, t}; end
            2'b10:   p = {32'h0, ma} * {32'h0, mb};
            default: begin
                sa = longint'($signed(ma));
                sb = longint'($signed(mb));
                p  = 64'(sa * sb);
            end
        endcase
        lng        = mop[1];
        e.lo       = p[31:0];
        e.hi       = lng ? p[63:32] : 32'h0;
        e.hi_we    = lng;
        e.flags[1] = lng ? p[63] : p[31];
        e.flags[0] = lng ? (p == 64'h0) : (p[31:0] == 32'h0);
        e.wl       = wl;
        e.wh       = wh;
        e.acc_cyc  = 0;
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (expq.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                ce = expq.pop_front();
                chk("sb_lo", lo, ce.lo);
                chk("sb_hi", hi, ce.hi);
                chk("sb_hi_we", 32'(hi_we), 32'(ce.hi_we));
                chk("sb_flags", 32'(flags), 32'(ce.flags));
                chk("sb_wa_lo", 32'(wa_lo), 32'(ce.wl));
                chk("sb_wa_hi", 32'(wa_hi), 32'(ce.wh));
                chk("sb_latency", 32'(cyc - ce.acc_cyc), 32'(LATENCY));
                chk("sb_busy_low", 32'(busy), 32'(0));
            end
        end
    end

    // Present a request for one cycle; accepted at the next posedge.
    task automatic drive_start(input logic [1:0] dop, input logic [31:0] da, input logic [31:0] db,
                               input logic [31:0] dacc, input logic [3:0] wl, input logic [3:0] wh,
                               input bit expect_accept);
        exp_t e;
        op = dop; a = da; b = db; acc = dacc; wa_lo_in = wl; wa_hi_in = wh;
        start = 1'b1;
        if (expect_accept) begin
            e = model(dop, da, db, dacc, wl, wh);
            e.acc_cyc = cyc + 1;
            expq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h1234_5678; acc = 32'hFFFF_0000;
        wa_lo_in = 4'hF; wa_hi_in = 4'hE;
    endtask

    task automatic issue(input logic [1:0] dop, input logic [31:0] da, input logic [31:0] db,
                         input logic [31:0] dacc, input logic [3:0] wl, input logic [3:0] wh);
        @(negedge clk);
        drive_start(dop, da, db, dacc, wl, wh, 1'b1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run(input logic [1:0] dop, input logic [31:0] da, input logic [31:0] db,
                       input logic [31:0] dacc, input logic [3:0] wl, input logic [3:0] wh);
        issue(dop, da, db, dacc, wl, wh);
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t m;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; acc = '0;
        wa_lo_in = '0; wa_hi_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_lo", lo, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_hi_we", 32'(hi_we), 32'(0));
        chk("rst_wa", 32'({wa_lo, wa_hi}), 32'(0));
        chk("rst_flags", 32'(flags), 32'(0));
        reset = 1'b0;

        // Pin the reference model against hand-computed products.
        m = model(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'h0, 4'h0);
        chk("pin_umull_hi", m.hi, 32'hFFFF_FFFE);
        chk("pin_umull_lo", m.lo, 32'h0000_0001);
        m = model(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0, 4'h0, 4'h0);
        chk("pin_smull_min", m.hi, 32'h4000_0000);
        m = model(2'b01, 32'd5, 32'd7, 32'd100, 4'h0, 4'h0);
        chk("pin_mla_lo", m.lo, 32'h0000_0087);

        // UMULL all-ones
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd1, 4'd2);
        chk("umull_hi", hi, 32'hFFFF_FFFE);
        chk("umull_lo", lo, 32'h0000_0001);
        chk("umull_flags", 32'(flags), 32'(2'b10));

        // SMULL signed cases
        run(2'b11, 32'hFFFF_FFFE, 32'd3, 32'h0, 4'd5, 4'd6);
        chk("smull_hi", hi, 32'hFFFF_FFFF);
        chk("smull_lo", lo, 32'hFFFF_FFFA);
        chk("smull_flags", 32'(flags), 32'(2'b10));
        chk("smull_hi_we", 32'(hi_we), 32'(1));
        run(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0, 4'd0, 4'd1);
        chk("smull_min_hi", hi, 32'h4000_0000);
        chk("smull_min_lo", lo, 32'h0);

        // MLA and MUL
        run(2'b01, 32'd5, 32'd7, 32'd100, 4'd7, 4'd8);
        chk("mla_lo", lo, 32'h0000_0087);
        chk("mla_hi", hi, 32'h0);
        chk("mla_hi_we", 32'(hi_we), 32'(0));
        run(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'd2, 4'd3);
        chk("mul_lo", lo, 32'h0);
        chk("mul_flags", 32'(flags), 32'(2'b01));

        // Extra vectors checked by the model only
        run(2'b11, 32'd7, 32'hFFFF_FFFB, 32'h0, 4'd9, 4'd10);
        run(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'd11, 4'd12);
        run(2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'd13, 4'd14);
        run(2'b01, 32'hFFFF_FFFF, 32'd1, 32'd2, 4'd15, 4'd0);
        run(2'b11, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'd1, 4'd1);
        run(2'b00, 32'hFFFF_FFFD, 32'd4, 32'h0, 4'd2, 4'd2);

        // Starts while busy are ignored; start in the DONE cycle is accepted
        issue(2'b10, 32'd1000, 32'd3000, 32'h0, 4'd4, 4'd5);
        repeat (2) @(negedge clk);
        drive_start(2'b00, 32'd9, 32'd9, 32'h0, 4'd6, 4'd6, 1'b0);
        repeat (6) @(negedge clk);
        drive_start(2'b01, 32'd2, 32'd2, 32'd2, 4'd7, 4'd7, 1'b0);
        chk("busy_during_calc", 32'(busy), 32'(1));
        wait_done();
        chk("b2b_old_lo", lo, 32'd3000000);
        chk("b2b_done_busy", 32'(busy), 32'(0));
        drive_start(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd8, 4'd9, 1'b1);
        chk("b2b_busy_next", 32'(busy), 32'(1));
        chk("b2b_done_cleared", 32'(done), 32'(0));
        wait_done();
        chk("b2b_new_lo", lo, 32'h1);

        // Asynchronous reset mid-CALC aborts without a done pulse
        issue(2'b10, 32'h0001_0001, 32'h0000_0003, 32'h0, 4'd1, 4'd2);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_lo", lo, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_done", 32'(done), 32'(0));
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done_q", 32'(expq.size()), 32'(0));
        run(2'b00, 32'd6, 32'd7, 32'h0, 4'd3, 4'd3);
        chk("post_abort_lo", lo, 32'd42);

        // Write addresses captured on accept despite input changes while busy
        run(2'b10, 32'd2, 32'd2, 32'h0, 4'd3, 4'd4);
        chk("wa_lo_capt", 32'(wa_lo), 32'd3);
        chk("wa_hi_capt", 32'(wa_hi), 32'd4);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
